axi_read_master_nch: RTL and testbench
======================================

# axi_read_master_nch

Multi-channel AXI3-style read master: NUM_CH request queues, one per requester, are written by the testbench or an upstream block. A round-robin arbiter issues their requests on a single AR channel. Each AXI ID may have one burst in flight; R beats are tracked per ID and checked for length and response. Each beat is then presented on a registered read-data output with an error flag. This block is the parametrised successor of the two-queue read master and sits between request generators and the AXI interconnect/slave.

## Interface
- BusWidth, 32: ARADDR and RDATA width.
- tagbits, 1: AXI ID width; 2**tagbits IDs are tracked.
- NUM_CH, 2: number of request queues, 2..8.
- FIFO_DEPTH, 4: entries per queue, power of two, ≥2.
- REQ_W, tagbits+BusWidth+17: packed request width, derived, not overridden.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- req_write  in  NUM_CH  push strobe per queue.
- req_in  in  NUM_CH*REQ_W  packed requests; queue k uses slice [k*REQ_W +: REQ_W].
- req_full  out  NUM_CH  queue k full; a push while full is dropped.
- ARID, ARADDR, ARLEN[3:0], ARSIZE[1:0], ARBURST[1:0], ARLOCK[1:0], ARCACHE[3:0], ARPROT[2:0]  out  registered AR fields.
- ARVALID  out  1;  ARREADY  in  1.
- RID  in  tagbits;  RDATA  in  BusWidth;  RRESP  in  2;  RLAST  in  1;  RVALID  in  1;  RREADY  out  1.
- rd_valid  out  1  one-cycle strobe, one per accepted R beat.
- rd_data  out  BusWidth;  rd_id  out  tagbits;  rd_last  out  1;  rd_err  out  1.

## Operation
- Request packing, MSB→LSB: ID, ADDR, LEN, SIZE, BURST, LOCK, CACHE, PROT. ARLEN must be ≤3; a larger value is clamped to 3 on issue.
- Queues: a simultaneous push and pop on a non-empty queue keeps the count unchanged. A push to a full queue is ignored.
- Eligibility: queue k is eligible when it is non-empty and the ID of its head entry is not busy.
- Round-robin: the search starts at (last_grant+1) mod NUM_CH. last_grant resets to NUM_CH-1, so queue 0 wins first.
- AR FSM, state IDLE:
  - If any queue is eligible: pop the granted head, load all AR registers, set busy[ID], load exp_len[ID]=ARLEN, clear beat_cnt[ID] and err_acc[ID], go to ISSUE.
  - Otherwise stay in IDLE with ARVALID=0.
- AR FSM, state ISSUE:
  - ARVALID=1 and all AR fields stay stable until ARREADY is high on a rising edge.
  - On that handshake, go to IDLE and update last_grant.
  - ARVALID is never withdrawn before the handshake.
- R channel: RREADY=1 whenever not in reset; every cycle with RVALID=1 is an accepted beat.
- Per-beat check:
  - err_acc[RID] |= (RRESP≠0).
  - The beat is in error if busy[RID]=0, if RLAST=1 with beat_cnt≠exp_len, or if RLAST=0 with beat_cnt=exp_len.
  - beat_cnt[RID] increments on each non-last beat.
- On RLAST: busy[RID] clears and beat_cnt[RID] resets.
- If an R beat and an AR issue target the same ID in the same cycle, this is impossible by construction; the issue side requires busy=0.
- Interleaved beats of different IDs are legal and tracked independently.

## Timing
- Reset values:
  - All AR fields 0, ARVALID 0, RREADY 0.
  - rd_* all 0.
  - req_full 0, all queues empty.
  - busy, beat_cnt and err_acc all 0.
  - AR FSM in IDLE.
- Reset asserted mid-burst aborts all tracking and empties all queues; in-flight R beats after reset are flagged rd_err.
- Latency from a push into an empty queue (edge N) with the ID idle:
  - Grant at edge N+1.
  - ARVALID high after edge N+1.
  - With ARREADY=1, the handshake completes at edge N+2.
- Throughput is at most one AR every 2 cycles, because IDLE costs one bubble cycle.
- R beat accepted at edge M: rd_valid, rd_data, rd_id and rd_last are registered and valid after edge M, for one cycle.
- rd_err = beat error OR (RLAST AND (err_acc OR current RRESP≠0)).

## Structure
- Package axi_rd_pkg holds:
  - request field offsets and the REQ_W function;
  - the AR state encoding (IDLE, ISSUE);
  - RRESP constants: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3;
  - LEN_MAX=3.
- Sub-module req_fifo (parameters REQ_W and FIFO_DEPTH; outputs head data combinationally, empty and full), instantiated NUM_CH times via generate.
- The round-robin arbiter and the per-ID tables remain inline.

## Test plan
- NUM_CH=2, one request per queue pushed together with ARREADY=1: AR issues queue 0 and then queue 1, with ARVALID low for exactly one cycle between them.
- ARREADY held low for 5 cycles during ISSUE: ARVALID and ARADDR stay stable all 5 cycles and the queue count does not change again.
- Queue 0 head has ID0 in flight and queue 1 head has ID1: queue 1 is issued first while queue 0 waits; queue 0 issues one cycle after RLAST for ID0.
- ARLEN=3 answered with 4 OKAY beats, RLAST on beat 4: four rd_valid strobes, rd_last on the 4th, rd_err=0 throughout.
- ARLEN=3 answered with RLAST on beat 2, then RRESP=SLVERR on a separate burst: rd_err=1 on the early last beat, busy clears, and the SLVERR burst flags rd_err on its last beat.
- FIFO_DEPTH=4: push 5 requests while ARREADY=0: req_full goes high after the 4th push and the 5th request is never issued.

Source files
------------

// File: rtl/axi_rd_pkg.sv
// Shared definitions for the multi-channel AXI read master: request layout,
// AR state encoding and response codes.
package axi_rd_pkg;

  // Request control field widths.
  localparam int LEN_W   = 4;
  localparam int SIZE_W  = 2;
  localparam int BURST_W = 2;
  localparam int LOCK_W  = 2;
  localparam int CACHE_W = 4;
  localparam int PROT_W  = 3;

  // Field offsets from the LSB of a packed request (ID, ADDR, LEN, SIZE, BURST, LOCK, CACHE, PROT).
  localparam int PROT_LSB  = 0;
  localparam int CACHE_LSB = PROT_LSB  + PROT_W;
  localparam int LOCK_LSB  = CACHE_LSB + CACHE_W;
  localparam int BURST_LSB = LOCK_LSB  + LOCK_W;
  localparam int SIZE_LSB  = BURST_LSB + BURST_W;
  localparam int LEN_LSB   = SIZE_LSB  + SIZE_W;
  localparam int ADDR_LSB  = LEN_LSB   + LEN_W;
  localparam int CTRL_W    = ADDR_LSB;

  // Longest burst this master will issue (ARLEN encoding, beats-1).
  localparam logic [LEN_W-1:0] LEN_MAX = 4'd3;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ar_state_t;

  // Packed request width for a given ID and address width.
  function automatic int req_w(input int id_w, input int addr_w);
    return id_w + addr_w + CTRL_W;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Request queue: power-of-two depth, head visible combinationally,
// pushes while full are dropped.
module req_fifo #(
  parameter int REQ_W      = 50,
  parameter int FIFO_DEPTH = 4
)(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [REQ_W-1:0] i_data,
  input  logic             i_pop,
  output logic [REQ_W-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [REQ_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers and occupancy; simultaneous push and pop leaves the count alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axi_read_master_nch.sv
// Multi-channel AXI3 read master: NUM_CH request queues, round-robin onto a
// single AR channel, one burst in flight per ID, per-ID R beat checking.
//
// state | meaning
// IDLE  | no AR pending; grants an eligible queue head (one bubble per AR)
// ISSUE | ARVALID held with stable fields until ARREADY
module axi_read_master_nch
  import axi_rd_pkg::*;
#(
  parameter int BusWidth   = 32,
  parameter int tagbits    = 1,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4
)(
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [NUM_CH-1:0]                      req_write,
  input  logic [NUM_CH*req_w(tagbits,BusWidth)-1:0] req_in,
  output logic [NUM_CH-1:0]                      req_full,
  output logic [tagbits-1:0]                     ARID,
  output logic [BusWidth-1:0]                    ARADDR,
  output logic [3:0]                             ARLEN,
  output logic [1:0]                             ARSIZE,
  output logic [1:0]                             ARBURST,
  output logic [1:0]                             ARLOCK,
  output logic [3:0]                             ARCACHE,
  output logic [2:0]                             ARPROT,
  output logic                                   ARVALID,
  input  logic                                   ARREADY,
  input  logic [tagbits-1:0]                     RID,
  input  logic [BusWidth-1:0]                    RDATA,
  input  logic [1:0]                             RRESP,
  input  logic                                   RLAST,
  input  logic                                   RVALID,
  output logic                                   RREADY,
  output logic                                   rd_valid,
  output logic [BusWidth-1:0]                    rd_data,
  output logic [tagbits-1:0]                     rd_id,
  output logic                                   rd_last,
  output logic                                   rd_err
);

  localparam int REQ_W  = req_w(tagbits, BusWidth);
  localparam int NUM_ID = 2**tagbits;
  localparam int CH_W   = $clog2(NUM_CH);

  // Queues
  logic [NUM_CH-1:0]  w_empty;
  logic [NUM_CH-1:0]  w_pop;
  logic [NUM_CH-1:0]  w_eligible;
  logic [REQ_W-1:0]   w_head    [NUM_CH];
  logic [tagbits-1:0] w_head_id [NUM_CH];

  // Arbiter / FSM
  ar_state_t          r_state;
  ar_state_t          w_state_nxt;
  logic [CH_W-1:0]    r_last_grant;
  logic [CH_W-1:0]    r_grant;
  logic [CH_W-1:0]    w_gnt;
  logic [CH_W-1:0]    w_cand;
  logic               w_any;
  logic               w_load;
  logic               w_ar_done;

  // AR registers
  logic [tagbits-1:0]  r_arid;
  logic [BusWidth-1:0] r_araddr;
  logic [3:0]          r_arlen;
  logic [1:0]          r_arsize;
  logic [1:0]          r_arburst;
  logic [1:0]          r_arlock;
  logic [3:0]          r_arcache;
  logic [2:0]          r_arprot;

  // Selected head fields
  logic [REQ_W-1:0]    w_sel;
  logic [tagbits-1:0]  w_sel_id;
  logic [LEN_W-1:0]    w_sel_len;
  logic [LEN_W-1:0]    w_sel_len_clamp;

  // Per-ID tracking
  logic [NUM_ID-1:0]   r_busy;
  logic [1:0]          r_exp_len  [NUM_ID];
  logic [1:0]          r_beat_cnt [NUM_ID];
  logic [NUM_ID-1:0]   r_err_acc;

  // R side
  logic                w_rready;
  logic                w_rbeat;
  logic                w_beat_err;
  logic                w_resp_err;
  logic                r_rd_valid;
  logic [BusWidth-1:0] r_rd_data;
  logic [tagbits-1:0]  r_rd_id;
  logic                r_rd_last;
  logic                r_rd_err;

  genvar k;
  generate
    for (k = 0; k < NUM_CH; k++) begin : g_q
      req_fifo #(
        .REQ_W      (REQ_W),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_push  (req_write[k]),
        .i_data  (req_in[k*REQ_W +: REQ_W]),
        .i_pop   (w_pop[k]),
        .o_head  (w_head[k]),
        .o_empty (w_empty[k]),
        .o_full  (req_full[k])
      );
      assign w_head_id[k]  = w_head[k][REQ_W-1 -: tagbits];
      assign w_eligible[k] = ~w_empty[k] & ~r_busy[w_head_id[k]];
    end
  endgenerate

  // Round-robin search starting just after the last granted queue.
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = '0;
    w_cand = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cand = CH_W'((int'(r_last_grant) + 1 + i) % NUM_CH);
      if (!w_any && w_eligible[w_cand]) begin
        w_any = 1'b1;
        w_gnt = w_cand;
      end
    end
  end

  assign w_sel           = w_head[w_gnt];
  assign w_sel_id        = w_sel[REQ_W-1 -: tagbits];
  assign w_sel_len       = w_sel[LEN_LSB +: LEN_W];
  assign w_sel_len_clamp = (w_sel_len > LEN_MAX) ? LEN_MAX : w_sel_len;

  // AR state register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // AR next state: grant and pop in IDLE, hold in ISSUE until ARREADY.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ar_done   = 1'b0;
    w_pop       = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_load       = 1'b1;
          w_pop[w_gnt] = 1'b1;
          w_state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (ARREADY) begin
          w_ar_done   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // AR field registers and round-robin pointer.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_arid       <= '0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arsize     <= '0;
      r_arburst    <= '0;
      r_arlock     <= '0;
      r_arcache    <= '0;
      r_arprot     <= '0;
      r_grant      <= '0;
      r_last_grant <= CH_W'(NUM_CH - 1);
    end else begin
      if (w_load) begin
        r_arid    <= w_sel_id;
        r_araddr  <= w_sel[ADDR_LSB +: BusWidth];
        r_arlen   <= w_sel_len_clamp;
        r_arsize  <= w_sel[SIZE_LSB +: SIZE_W];
        r_arburst <= w_sel[BURST_LSB +: BURST_W];
        r_arlock  <= w_sel[LOCK_LSB +: LOCK_W];
        r_arcache <= w_sel[CACHE_LSB +: CACHE_W];
        r_arprot  <= w_sel[PROT_LSB +: PROT_W];
        r_grant   <= w_gnt;
      end
      if (w_ar_done) r_last_grant <= r_grant;
    end
  end

  assign ARID    = r_arid;
  assign ARADDR  = r_araddr;
  assign ARLEN   = r_arlen;
  assign ARSIZE  = r_arsize;
  assign ARBURST = r_arburst;
  assign ARLOCK  = r_arlock;
  assign ARCACHE = r_arcache;
  assign ARPROT  = r_arprot;
  assign ARVALID = (r_state == ISSUE);

  assign w_rready   = ~ARESET;
  assign RREADY     = w_rready;
  assign w_rbeat    = RVALID & w_rready;
  assign w_resp_err = (RRESP != RESP_OKAY);
  assign w_beat_err = ~r_busy[RID] |
                      (RLAST ? (r_beat_cnt[RID] != r_exp_len[RID])
                             : (r_beat_cnt[RID] == r_exp_len[RID]));

  // Per-ID tables; an issue overrides any stray beat for the same ID.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_busy    <= '0;
      r_err_acc <= '0;
      for (int i = 0; i < NUM_ID; i++) begin
        r_exp_len[i]  <= '0;
        r_beat_cnt[i] <= '0;
      end
    end else begin
      if (w_rbeat) begin
        if (w_resp_err) r_err_acc[RID] <= 1'b1;
        if (RLAST) begin
          r_busy[RID]     <= 1'b0;
          r_beat_cnt[RID] <= '0;
        end else begin
          r_beat_cnt[RID] <= r_beat_cnt[RID] + 1'b1;
        end
      end
      if (w_load) begin
        r_busy[w_sel_id]     <= 1'b1;
        r_exp_len[w_sel_id]  <= w_sel_len_clamp[1:0];
        r_beat_cnt[w_sel_id] <= '0;
        r_err_acc[w_sel_id]  <= 1'b0;
      end
    end
  end

  // Registered read-data presentation, one strobe per accepted beat.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_id    <= '0;
      r_rd_last  <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= w_rbeat;
      r_rd_last  <= w_rbeat & RLAST;
      r_rd_err   <= w_rbeat & (w_beat_err | (RLAST & (r_err_acc[RID] | w_resp_err)));
      if (w_rbeat) begin
        r_rd_data <= RDATA;
        r_rd_id   <= RID;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_id    = r_rd_id;
  assign rd_last  = r_rd_last;
  assign rd_err   = r_rd_err;

endmodule

// File: tb/tb_axi_read_master_nch.sv
// Directed bench for axi_read_master_nch with default parameters
// (32-bit data, 1-bit ID, two queues of depth four).
module tb_axi_read_master_nch;

  localparam int RW = 50;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [1:0]    req_write;
  logic [2*RW-1:0] req_in;
  logic [1:0]    req_full;
  logic          ARID;
  logic [31:0]   ARADDR;
  logic [3:0]    ARLEN;
  logic [1:0]    ARSIZE, ARBURST, ARLOCK;
  logic [3:0]    ARCACHE;
  logic [2:0]    ARPROT;
  logic          ARVALID, ARREADY;
  logic          RID;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RLAST, RVALID, RREADY;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic          rd_id, rd_last, rd_err;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 ACLK = ~ACLK;

  axi_read_master_nch dut (
    .ACLK(ACLK), .ARESET(ARESET), .req_write(req_write), .req_in(req_in), .req_full(req_full),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_id(rd_id), .rd_last(rd_last), .rd_err(rd_err)
  );

  // id, addr, len, size=2, burst=INCR, lock=0, cache=3, prot=2
  function automatic logic [RW-1:0] mk_req(input logic id, input logic [31:0] addr, input logic [3:0] len);
    return {id, addr, len, 2'b10, 2'b01, 2'b00, 4'b0011, 3'b010};
  endfunction

  task automatic tick();
    @(posedge ACLK); #1;
  endtask

  task automatic push(input int ch, input logic [RW-1:0] d);
    req_write = '0;
    req_write[ch] = 1'b1;
    req_in[ch*RW +: RW] = d;
    tick();
    req_write = '0;
  endtask

  task automatic rbeat(input logic id, input logic [31:0] d, input logic [1:0] resp, input logic last);
    RVALID = 1'b1; RID = id; RDATA = d; RRESP = resp; RLAST = last;
    tick();
    RVALID = 1'b0; RLAST = 1'b0;
  endtask

  task automatic wait_ar(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ARVALID === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    req_write = '0; req_in = '0; ARREADY = 1'b0;
    RID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
    tick(); tick();
    n_cmp++; if (ARVALID !== 1'b0) begin n_mis++; $display("FAIL reset_arvalid: got %b want 0", ARVALID); end
    n_cmp++; if (RREADY !== 1'b0) begin n_mis++; $display("FAIL reset_rready: got %b want 0", RREADY); end
    n_cmp++; if (ARADDR !== 32'h0) begin n_mis++; $display("FAIL reset_araddr: got %h want 0", ARADDR); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_mis++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (req_full !== 2'b00) begin n_mis++; $display("FAIL reset_req_full: got %b want 00", req_full); end
    ARESET = 1'b0;
    tick();
    n_cmp++; if (RREADY !== 1'b1) begin n_mis++; $display("FAIL rready_after_reset: got %b want 1", RREADY); end
    n_cmp++; if (ARVALID !== 1'b0) begin n_mis++; $display("FAIL idle_arvalid: got %b want 0", ARVALID); end
  endtask

  task automatic test_round_robin();
    ARREADY = 1'b1;
    req_write = 2'b11;
    req_in = {mk_req(1'b1, 32'h0000_1100, 4'd0), mk_req(1'b0, 32'h0000_1000, 4'd0)};
    tick();
    req_write = '0;
    n_cmp++; if (ARVALID !== 1'b0) begin n_mis++; $display("FAIL rr_push_edge: got %b want 0", ARVALID); end
    tick();
    n_cmp++; if (ARVALID !== 1'b1) begin n_mis++; $display("FAIL rr_first_valid: got %b want 1", ARVALID); end
    n_cmp++; if (ARADDR !== 32'h0000_1000) begin n_mis++; $display("FAIL rr_first_addr: got %h want 00001000", ARADDR); end
    n_cmp++; if (ARID !== 1'b0) begin n_mis++; $display("FAIL rr_first_id: got %b want 0", ARID); end
    n_cmp++; if ({ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT} !== {2'b10, 2'b01, 2'b00, 4'b0011, 3'b010})
      begin n_mis++; $display("FAIL rr_fields: got %b want 1001000011010", {ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT}); end
    tick();
    n_cmp++; if (ARVALID !== 1'b0) begin n_mis++; $display("FAIL rr_bubble: got %b want 0", ARVALID); end
    tick();
    n_cmp++; if (ARVALID !== 1'b1) begin n_mis++; $display("FAIL rr_second_valid: got %b want 1", ARVALID); end
    n_cmp++; if (ARADDR !== 32'h0000_1100) begin n_mis++; $display("FAIL rr_second_addr: got %h want 00001100", ARADDR); end
    n_cmp++; if (ARID !== 1'b1) begin n_mis++; $display("FAIL rr_second_id: got %b want 1", ARID); end
    tick();
    n_cmp++; if (ARVALID !== 1'b0) begin n_mis++; $display("FAIL rr_done: got %b want 0", ARVALID); end
    rbeat(1'b0, 32'hA0A0_0000, 2'b00, 1'b1);
    n_cmp++; if ({rd_valid, rd_id, rd_last, rd_err} !== 4'b1010) begin n_mis++; $display("FAIL rr_beat0_flags: got %b want 1010", {rd_valid, rd_id, rd_last, rd_err}); end
    n_cmp++; if (rd_data !== 32'hA0A0_0000) begin n_mis++; $display("FAIL rr_beat0_data: got %h want a0a00000", rd_data); end
    rbeat(1'b1, 32'hA1A1_0000, 2'b00, 1'b1);
    n_cmp++; if ({rd_valid, rd_id, rd_last, rd_err} !== 4'b1110) begin n_mis++; $display("FAIL rr_beat1_flags: got %b want 1110", {rd_valid, rd_id, rd_last, rd_err}); end
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_mis++; $display("FAIL rr_strobe_len: got %b want 0", rd_valid); end
  endtask

  task automatic test_busy_block();
    bit ok;
    ARREADY = 1'b1;
    push(1, mk_req(1'b0, 32'h0000_3000, 4'd0));
    wait_ar(ok);
    n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL bb_w_timeout: got %b want 1", ok); end
    n_cmp++; if (ARADDR !== 32'h0000_3000) begin n_mis++; $display("FAIL bb_w_addr: got %h want 00003000", ARADDR); end
    tick();
    req_write = 2'b11;
    req_in = {mk_req(1'b1, 32'h0000_3200, 4'd0), mk_req(1'b0, 32'h0000_3100, 4'd0)};
    tick();
    req_write = '0;
    wait_ar(ok);
    n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL bb_z_timeout: got %b want 1", ok); end
    n_cmp++; if (ARADDR !== 32'h0000_3200) begin n_mis++; $display("FAIL bb_z_first: got %h want 00003200", ARADDR); end
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (ARVALID !== 1'b0) begin n_mis++; $display("FAIL bb_blocked_%0d: got %b want 0", i, ARVALID); end
    end
    rbeat(1'b0, 32'h0000_0033, 2'b00, 1'b1);
    n_cmp++; if ({ARVALID, rd_err} !== 2'b00) begin n_mis++; $display("FAIL bb_rlast_edge: got %b want 00", {ARVALID, rd_err}); end
    tick();
    n_cmp++; if (ARVALID !== 1'b1) begin n_mis++; $display("FAIL bb_y_valid: got %b want 1", ARVALID); end
    n_cmp++; if (ARADDR !== 32'h0000_3100) begin n_mis++; $display("FAIL bb_y_addr: got %h want 00003100", ARADDR); end
    tick();
    rbeat(1'b1, 32'h0000_0034, 2'b00, 1'b1);
    n_cmp++; if (rd_err !== 1'b0) begin n_mis++; $display("FAIL bb_z_done: got %b want 0", rd_err); end
    rbeat(1'b0, 32'h0000_0035, 2'b00, 1'b1);
    n_cmp++; if (rd_err !== 1'b0) begin n_mis++; $display("FAIL bb_y_done: got %b want 0", rd_err); end
  endtask

  task automatic test_burst4();
    bit ok;
    ARREADY = 1'b1;
    push(0, mk_req(1'b0, 32'h0000_4000, 4'd3));
    wait_ar(ok);
    n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL b4_timeout: got %b want 1", ok); end
    n_cmp++; if (ARLEN !== 4'd3) begin n_mis++; $display("FAIL b4_arlen: got %0d want 3", ARLEN); end
    tick();
    for (int b = 0; b < 4; b++) begin
      rbeat(1'b0, 32'hD000_0000 + 32'(b), 2'b00, b == 3);
      n_cmp++; if ({rd_valid, rd_last, rd_err} !== {1'b1, (b == 3), 1'b0})
        begin n_mis++; $display("FAIL b4_beat%0d_flags: got %b want %b", b, {rd_valid, rd_last, rd_err}, {1'b1, (b == 3), 1'b0}); end
      n_cmp++; if (rd_data !== 32'hD000_0000 + 32'(b)) begin n_mis++; $display("FAIL b4_beat%0d_data: got %h want %h", b, rd_data, 32'hD000_0000 + 32'(b)); end
    end
    tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_mis++; $display("FAIL b4_quiet: got %b want 0", rd_valid); end
  endtask

  task automatic test_errors();
    bit ok;
    ARREADY = 1'b1;
    push(1, mk_req(1'b1, 32'h0000_5000, 4'd7));
    wait_ar(ok);
    n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL er_timeout1: got %b want 1", ok); end
    n_cmp++; if (ARLEN !== 4'd3) begin n_mis++; $display("FAIL er_clamp: got %0d want 3", ARLEN); end
    tick();
    rbeat(1'b1, 32'h0000_0051, 2'b00, 1'b0);
    n_cmp++; if (rd_err !== 1'b0) begin n_mis++; $display("FAIL er_beat1: got %b want 0", rd_err); end
    rbeat(1'b1, 32'h0000_0052, 2'b00, 1'b1);
    n_cmp++; if ({rd_last, rd_err} !== 2'b11) begin n_mis++; $display("FAIL er_early_last: got %b want 11", {rd_last, rd_err}); end
    push(1, mk_req(1'b1, 32'h0000_6000, 4'd1));
    wait_ar(ok);
    n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL er_busy_clear: got %b want 1", ok); end
    n_cmp++; if (ARADDR !== 32'h0000_6000) begin n_mis++; $display("FAIL er_slv_addr: got %h want 00006000", ARADDR); end
    tick();
    rbeat(1'b1, 32'h0000_0061, 2'b10, 1'b0);
    n_cmp++; if (rd_err !== 1'b0) begin n_mis++; $display("FAIL er_slv_mid: got %b want 0", rd_err); end
    rbeat(1'b1, 32'h0000_0062, 2'b00, 1'b1);
    n_cmp++; if ({rd_last, rd_err} !== 2'b11) begin n_mis++; $display("FAIL er_slv_last: got %b want 11", {rd_last, rd_err}); end
  endtask

  task automatic test_stall_full();
    bit ok;
    logic [31:0] addrs [5];
    for (int j = 0; j < 5; j++) addrs[j] = 32'h0000_7000 + 32'(j * 16);
    ARREADY = 1'b0;
    push(0, mk_req(1'b0, 32'h0000_8000, 4'd1));
    tick();
    n_cmp++; if (ARVALID !== 1'b1) begin n_mis++; $display("FAIL st_valid: got %b want 1", ARVALID); end
    for (int j = 0; j < 5; j++) begin
      push(1, mk_req(1'b1, addrs[j], 4'd0));
      n_cmp++; if ({ARVALID, ARADDR} !== {1'b1, 32'h0000_8000}) begin n_mis++; $display("FAIL st_stable_%0d: got %b/%h want 1/00008000", j, ARVALID, ARADDR); end
      n_cmp++; if (req_full !== {(j >= 3), 1'b0}) begin n_mis++; $display("FAIL st_full_%0d: got %b want %b", j, req_full, {(j >= 3), 1'b0}); end
    end
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    n_cmp++; if (ARVALID !== 1'b0) begin n_mis++; $display("FAIL st_handshake: got %b want 0", ARVALID); end
    rbeat(1'b0, 32'h0000_0081, 2'b00, 1'b0);
    rbeat(1'b0, 32'h0000_0082, 2'b00, 1'b1);
    n_cmp++; if ({rd_last, rd_err} !== 2'b10) begin n_mis++; $display("FAIL st_id0_done: got %b want 10", {rd_last, rd_err}); end
    n_cmp++; if (req_full !== 2'b00) begin n_mis++; $display("FAIL st_full_drop: got %b want 00", req_full); end
    ARREADY = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_ar(ok);
      n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL st_q1_timeout_%0d: got %b want 1", j, ok); end
      n_cmp++; if (ARADDR !== addrs[j]) begin n_mis++; $display("FAIL st_q1_addr_%0d: got %h want %h", j, ARADDR, addrs[j]); end
      tick();
      rbeat(1'b1, 32'h0000_0090 + 32'(j), 2'b00, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (ARVALID !== 1'b0) begin n_mis++; $display("FAIL st_fifth_issued_%0d: got %b want 0", i, ARVALID); end
    end
  endtask

  task automatic test_reset_midburst();
    bit ok;
    ARREADY = 1'b1;
    push(0, mk_req(1'b0, 32'h0000_9000, 4'd3));
    wait_ar(ok);
    n_cmp++; if (ok !== 1'b1) begin n_mis++; $display("FAIL rm_timeout: got %b want 1", ok); end
    tick();
    rbeat(1'b0, 32'h0000_0091, 2'b00, 1'b0);
    n_cmp++; if (rd_err !== 1'b0) begin n_mis++; $display("FAIL rm_first_beat: got %b want 0", rd_err); end
    ARREADY = 1'b0;
    push(1, mk_req(1'b1, 32'h0000_9100, 4'd0));
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    n_cmp++; if ({ARVALID, rd_valid, ARADDR} !== {2'b00, 32'h0}) begin n_mis++; $display("FAIL rm_reset_state: got %b/%b/%h want 0/0/0", ARVALID, rd_valid, ARADDR); end
    rbeat(1'b0, 32'h0000_0092, 2'b00, 1'b0);
    n_cmp++; if ({rd_valid, rd_err} !== 2'b11) begin n_mis++; $display("FAIL rm_stray_beat: got %b want 11", {rd_valid, rd_err}); end
    tick();
    n_cmp++; if (ARVALID !== 1'b0) begin n_mis++; $display("FAIL rm_queue_flushed: got %b want 0", ARVALID); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_busy_block();
    test_burst4();
    test_errors();
    test_stall_full();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
